vmask_reduce: RTL and testbench

- Pipelined mask-reduction unit for the vALU: the consumer counterpart of the element-index generator.
- Reads a mask operand streamed as one or more beats of REQ_DATA_WIDTH mask bits. Each bit i of a beat is element (in_start_idx + i).
- Reduces the stream to one scalar:
  - vcpop.m: count of active set bits.
  - vfirst.m: element index of the lowest active set bit, or -1 if none.
- Result is returned with the operation's address tag for scalar writeback.

---
 rtl/vmask_reduce.sv | 188 ++++++++++++++++++
 tb/tb_vmask_reduce.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmask_reduce.sv
// vmask_reduce: pipelined mask reduction for the vALU.
//
// Consumes a mask operand streamed as beats of REQ_DATA_WIDTH bits and
// reduces it to one scalar:
//   in_op = 0 : vcpop.m  -> count of active set bits
//   in_op = 1 : vfirst.m -> element index of lowest active set bit, or -1
//
// Pipeline: stage 0 (per-beat popcount / first-hit), stage 1 (accumulator
// FSM, IDLE/ACCUM), stage 2 (output register). The last beat sampled at edge k
// produces out_valid after edge k+2.
//
// Handshake: in_valid has no backpressure; every beat with in_valid=1 is
// consumed at the sampling edge. out_valid is a one-cycle strobe with no ready;
// out_addr/out_data hold their last value between strobes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid              beat valid
//   in_first, in_last     operation framing
//   in_op, in_addr        operation kind and tag (taken from the first beat)
//   in_start_idx          element index of bit 0 of the beat
//   in_vec, in_mask       source bits and active-element enables
//   out_addr, out_data    completed tag and scalar result
//   out_valid             result strobe
//   out_err               (only with VMASK_REDUCE_ERR_EN) sticky protocol error
//
// Optional feature macro: VMASK_REDUCE_ERR_EN.
module vmask_reduce #(
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic                       in_op,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_start_idx,
    input  logic [REQ_DATA_WIDTH-1:0]  in_vec,
    input  logic [REQ_DATA_WIDTH-1:0]  in_mask,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic [RESP_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid
`ifdef VMASK_REDUCE_ERR_EN
    ,
    output logic                       out_err
`endif
);

    localparam int IDX_W = $clog2(REQ_DATA_WIDTH);
    localparam int POP_W = IDX_W + 1;

    // ---------------- stage 0: per-beat reduction ----------------
    logic [REQ_DATA_WIDTH-1:0] beat_bits;
    logic [POP_W-1:0]          pop_c;
    logic [IDX_W-1:0]          lsb_c;

    // Scanning from the top down leaves the lowest set position in lsb_c.
    always_comb begin
        beat_bits = in_vec & in_mask;
        pop_c     = '0;
        lsb_c     = '0;
        for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
            pop_c = pop_c + POP_W'(beat_bits[i]);
            if (beat_bits[i]) lsb_c = IDX_W'(i);
        end
    end

    logic                      s0_valid, s0_first, s0_last, s0_op, s0_hit;
    logic [REQ_ADDR_WIDTH-1:0] s0_addr, s0_fidx;
    logic [POP_W-1:0]          s0_pop;

    always_ff @(posedge clk) begin
        if (rst || !in_valid) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_op    <= 1'b0;
            s0_hit   <= 1'b0;
            s0_addr  <= '0;
            s0_fidx  <= '0;
            s0_pop   <= '0;
        end else begin
            s0_valid <= 1'b1;
            s0_first <= in_first;
            s0_last  <= in_last;
            s0_op    <= in_op;
            s0_hit   <= |beat_bits;
            s0_addr  <= in_addr;
            s0_fidx  <= in_start_idx + REQ_ADDR_WIDTH'(lsb_c);
            s0_pop   <= pop_c;
        end
    end

    // ---------------- stage 1: accumulator FSM ----------------
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                     state_q, state_d;
    logic [RESP_DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                       found_q, found_d;
    logic [REQ_ADDR_WIDTH-1:0]  fidx_q, fidx_d;
    logic                       op_q, op_d;
    logic [REQ_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                       done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            found_q <= 1'b0;
            fidx_q  <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            fidx_q  <= fidx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        fidx_d  = fidx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        if (s0_valid) begin
            if (s0_first) begin
                // A first beat always (re)starts; any partial op is abandoned.
                cnt_d   = RESP_DATA_WIDTH'(s0_pop);
                found_d = s0_hit;
                fidx_d  = s0_fidx;
                op_d    = s0_op;
                addr_d  = s0_addr;
                done_d  = s0_last;
                state_d = s0_last ? IDLE : ACCUM;
            end else if (state_q == ACCUM) begin
                cnt_d = cnt_q + RESP_DATA_WIDTH'(s0_pop);
                // Beats arrive in ascending index order: first hit wins.
                if (!found_q && s0_hit) begin
                    found_d = 1'b1;
                    fidx_d  = s0_fidx;
                end
                done_d  = s0_last;
                state_d = s0_last ? IDLE : ACCUM;
            end
            // Non-first beat in IDLE is dropped.
        end
    end

`ifdef VMASK_REDUCE_ERR_EN
    logic viol;
    always_comb begin
        viol = s0_valid && (s0_first ? (state_q == ACCUM) : (state_q == IDLE));
    end

    always_ff @(posedge clk) begin
        if (rst) out_err <= 1'b0;
        else if (viol) out_err <= 1'b1;
    end
`endif

    // ---------------- stage 2: output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= done_q;
            if (done_q) begin
                out_addr <= addr_q;
                if (op_q) out_data <= found_q ? RESP_DATA_WIDTH'(fidx_q) : '1;
                else      out_data <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_vmask_reduce.sv
// Testbench for vmask_reduce: directed scenarios plus randomized operations,
// checked against an element-by-element reference model and an expected queue
// of {tag, result} entries with their due cycle.
module tb_vmask_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_first, in_last, in_op;
    logic [31:0] in_addr, in_start_idx;
    logic [63:0] in_vec, in_mask;
    logic [31:0] out_addr;
    logic [63:0] out_data;
    logic        out_valid;
`ifdef VMASK_REDUCE_ERR_EN
    logic        out_err;
`endif

    always #5 clk = ~clk;

    vmask_reduce dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_last      (in_last),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_start_idx (in_start_idx),
        .in_vec       (in_vec),
        .in_mask      (in_mask),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_valid    (out_valid)
`ifdef VMASK_REDUCE_ERR_EN
        ,
        .out_err      (out_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // ---------------- reference model ----------------
    logic [95:0] exp_q[$];
    int          due_q[$];
    logic        m_active, m_op, m_found, m_err;
    logic [31:0] m_addr, m_fidx;
    logic [63:0] m_cnt;

    task automatic model_beat(input logic f, input logic l, input logic o,
                              input logic [31:0] a, input logic [31:0] s,
                              input logic [63:0] v, input logic [63:0] m);
        logic [63:0] b;
        logic [63:0] res;
        b = v & m;
        if (f) begin
            if (m_active) m_err = 1'b1;
            m_active = 1'b1;
            m_op     = o;
            m_addr   = a;
            m_cnt    = 64'd0;
            m_found  = 1'b0;
            m_fidx   = 32'd0;
        end else if (!m_active) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (b[i]) begin
                m_cnt = m_cnt + 64'd1;
                if (!m_found) begin
                    m_found = 1'b1;
                    m_fidx  = s + 32'(i);
                end
            end
        end
        if (l) begin
            if (m_op) res = m_found ? {32'd0, m_fidx} : {64{1'b1}};
            else      res = m_cnt;
            exp_q.push_back({m_addr, res});
            due_q.push_back(edge_n + 3);
            m_active = 1'b0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    logic [95:0] e;
                    int d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("out_addr", {32'd0, out_addr}, {32'd0, e[95:64]});
                    check("out_data", out_data, e[63:0]);
                    check("latency", 64'(edge_n), 64'(d));
                end
            end else if (due_q.size() != 0 && due_q[0] <= edge_n) begin
                check("missing_valid", 64'(out_valid), 64'd1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic beat(input logic f, input logic l, input logic o,
                        input logic [31:0] a, input logic [31:0] s,
                        input logic [63:0] v, input logic [63:0] m);
        @(negedge clk);
        in_valid     = 1'b1;
        in_first     = f;
        in_last      = l;
        in_op        = o;
        in_addr      = a;
        in_start_idx = s;
        in_vec       = v;
        in_mask      = m;
        model_beat(f, l, o, a, s, v, m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
            in_vec   = $urandom();
            in_mask  = {64{1'b1}};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        exp_q.delete();
        due_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_addr", {32'd0, out_addr}, 64'd0);
`ifdef VMASK_REDUCE_ERR_EN
        check("rst_out_err", 64'(out_err), 64'd0);
`endif
    endtask

    function automatic logic [63:0] rand_mask();
        case ($urandom_range(0, 3))
            0:       return {64{1'b1}};
            1:       return {$urandom(), $urandom()};
            2:       return {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: return 64'd0;
        endcase
    endfunction

    localparam logic [63:0] ONES = {64{1'b1}};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_op = 1'b0;
        in_addr = '0; in_start_idx = '0; in_vec = '0; in_mask = '0;
        m_active = 1'b0; m_op = 1'b0; m_found = 1'b0; m_err = 1'b0;
        m_addr = '0; m_fidx = '0; m_cnt = '0;
        do_reset();

        // 1: single-beat cpop
        beat(1, 1, 0, 32'h11, 0, 64'hF0F0_0000_0000_00FF, ONES);
        idle(4);
        // 2: single-beat vfirst, hit and no hit
        beat(1, 1, 1, 32'h22, 0, 64'h0000_0000_0000_0100, ONES);
        beat(1, 1, 1, 32'h23, 0, 64'h0000_0000_0000_0100, 64'd0);
        idle(4);
        // 3: three beats with gaps, later hit ignored
        beat(1, 0, 1, 32'h33, 0,   64'd0,    ONES); idle(2);
        beat(0, 0, 0, 32'h99, 64,  64'h10,   ONES); idle(2);
        beat(0, 1, 0, 32'h98, 128, 64'h1,    ONES);
        idle(4);
        // 4: back-to-back single-beat ops
        beat(1, 1, 0, 32'h100, 0, 64'h3, ONES);
        beat(1, 1, 0, 32'h200, 0, 64'h7, ONES);
        idle(4);
        // 5: restart and stray non-first beat
        beat(1, 0, 0, 32'h50, 0, 64'hFF, ONES);
        beat(1, 1, 0, 32'h51, 0, 64'h1,  ONES);
        beat(0, 1, 0, 32'h52, 0, 64'hF,  ONES);
        idle(5);
`ifdef VMASK_REDUCE_ERR_EN
        check("err_after_restart", 64'(out_err), 64'(m_err));
`endif
        // 6: reset mid-operation, then a fresh op
        beat(1, 0, 0, 32'h60, 0, ONES, ONES);
        do_reset();
        idle(4);
        beat(1, 1, 0, 32'h61, 0, ONES, ONES);
        idle(5);

        // randomized operations with occasional protocol violations
        for (int op_i = 0; op_i < 200; op_i++) begin
            int          nb;
            logic [31:0] base, tag;
            logic        o, trunc;
            nb    = $urandom_range(1, 4);
            base  = $urandom();
            tag   = $urandom();
            o     = 1'($urandom_range(0, 1));
            trunc = ($urandom_range(0, 9) == 0);
            for (int j = 0; j < nb; j++) begin
                logic l;
                l = (j == nb - 1) && !trunc;
                beat(j == 0, l, o, tag, base + 32'(j * 64), {$urandom(), $urandom()}, rand_mask());
                if (j != nb - 1) idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 14) == 0)
                beat(0, 1, 0, 32'hdead, 0, ONES, ONES);
            idle($urandom_range(0, 2));
        end
        idle(10);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef VMASK_REDUCE_ERR_EN
        check("err_final", 64'(out_err), 64'(m_err));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
